// File: rtl/panel_shift_io.sv
// panel_shift_io: board-side front-panel lamp/switch serialiser for the PDP8e.
// Lamp vectors go out MSB-first on a 74HC595 chain. Switches come back on a
// 74HC165 chain. Both chains share one serial clock.
// Bit 0 of each PDP-style [0:N] field is carried as the MSB of the
// corresponding descending vector here (An[14] is lamp A0, sr[11] is SR0).
// Optional build macro: PANEL_DEBOUNCE_EN. When it is defined, a switch
// sample is only published when it matches the previous frame's sample.
module panel_shift_io #(
    parameter int CLK_DIV  = 50,   // system clocks per serial tick, >= 2
    parameter int OUT_BITS = 28,   // runn + dsn + An, fixed
    parameter int IN_BITS  = 18    // sr + dsel, fixed
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] An,
    input  logic [11:0] dsn,
    input  logic        runn,
    output logic        sclk,
    output logic        sdo,
    output logic        rck,
    output logic        pl_n,
    input  logic        sdi,
    output logic [11:0] sr,
    output logic [5:0]  dsel,
    output logic        frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'(OUT_BITS - 1);
    localparam logic [4:0] IN_LEN   = 5'(IN_BITS);

    localparam logic [1:0] ST_LOAD     = 2'd0;
    localparam logic [1:0] ST_SHIFT_HI = 2'd1;
    localparam logic [1:0] ST_SHIFT_LO = 2'd2;
    localparam logic [1:0] ST_LATCH    = 2'd3;

    logic [DIV_W-1:0]    div;
    logic                tick;
    logic [1:0]          state;
    logic [4:0]          bitcnt;
    // Bits still to be sent; the bit currently on sdo is not kept here.
    logic [OUT_BITS-2:0] shift_out;
    logic [IN_BITS-1:0]  shift_in;
    logic                latch_now;
    logic                accept;

    assign tick = (div == DIV_LAST);

    // Leaving SHIFT_LO after the last bit is the single point where a
    // complete switch sample exists, so publishing is tied to that event.
    assign latch_now = tick && (state == ST_SHIFT_LO) && (bitcnt == LAST_BIT);

    // Serial tick divider: free-running 0..CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Frame sequencer and serial pins; every change lands on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOAD;
            bitcnt    <= '0;
            sclk      <= 1'b0;
            sdo       <= 1'b0;
            rck       <= 1'b0;
            pl_n      <= 1'b1;
            shift_out <= '0;
            shift_in  <= '0;
        end else if (tick) begin
            case (state)
                ST_LOAD: begin
                    // Lamps are snapshotted here only, so mid-frame changes
                    // wait for the next frame.
                    pl_n      <= 1'b1;
                    sdo       <= runn;
                    shift_out <= {dsn, An};
                    bitcnt    <= '0;
                    state     <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    sclk <= 1'b1;
                    // Closed switches pull low, so the sample is inverted.
                    // sdi is taken before the rising edge moves the 165.
                    if (bitcnt < IN_LEN) begin
                        shift_in <= {shift_in[IN_BITS-2:0], ~sdi};
                    end
                    state <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    sclk <= 1'b0;
                    if (bitcnt == LAST_BIT) begin
                        rck   <= 1'b1;
                        state <= ST_LATCH;
                    end else begin
                        // Next bit goes out on the falling edge, giving it a
                        // full tick of setup before the next rising edge.
                        sdo       <= shift_out[OUT_BITS-2];
                        shift_out <= {shift_out[OUT_BITS-3:0], 1'b0};
                        bitcnt    <= bitcnt + 5'd1;
                        state     <= ST_SHIFT_HI;
                    end
                end
                default: begin
                    // ST_LATCH: one tick of rck, then start the 165 load.
                    rck   <= 1'b0;
                    pl_n  <= 1'b0;
                    state <= ST_LOAD;
                end
            endcase
        end
    end

`ifdef PANEL_DEBOUNCE_EN
    logic [IN_BITS-1:0] prev_sample;

    // A sample is only trusted once two consecutive frames agree on it.
    assign accept = (shift_in == prev_sample);

    // Remember every frame's sample, published or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sample <= '0;
        end else if (latch_now) begin
            prev_sample <= shift_in;
        end
    end
`else
    assign accept = 1'b1;
`endif

    // Publish the switch sample as a whole so readers never see a partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr         <= '0;
            dsel       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (latch_now && accept) begin
                {sr, dsel} <= shift_in;
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_panel_shift_io.sv
// Directed bench for panel_shift_io with a behavioural 74HC165 chain model.
module tb_panel_shift_io;

    localparam int CLK_DIV = 2;
    localparam logic [11:0] SR_BASE   = 12'o7070;
    localparam logic [11:0] SR_FLIP   = 12'o7170;   // SR5 toggled
    localparam logic [5:0]  DSEL_BASE = 6'b000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] An;
    logic [11:0] dsn;
    logic        runn;
    logic        sclk, sdo, rck, pl_n, sdi;
    logic [11:0] sr;
    logic [5:0]  dsel;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Switch pins as seen by the 165 (closed switch reads 0).
    logic [17:0] pins;
    logic [17:0] chain;
    logic        sclk_q;

    // Results of the most recent captured frame.
    logic [27:0] f_bits;
    int          f_nb, f_rck, f_fd, f_pl, f_viol, f_rise;
    logic [11:0] f_srpre;
    bit          f_done;

    panel_shift_io #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .An(An), .dsn(dsn), .runn(runn),
        .sclk(sclk), .sdo(sdo), .rck(rck), .pl_n(pl_n), .sdi(sdi),
        .sr(sr), .dsel(dsel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 165 chain: parallel load while pl_n is low (and at power-up reset),
    // shift one place after each sclk rising edge.
    always @(posedge clk) begin
        if (reset || !pl_n) chain <= pins;
        else if (sclk && !sclk_q) chain <= {chain[16:0], 1'b1};
        sclk_q <= sclk;
    end
    assign sdi = chain[17];

    // Follow one frame up to the end of its rck pulse, optionally changing
    // lamps or pulsing reset once a given number of sclk rises have occurred.
    task automatic capture(input int rst_at, input int chg_at, input logic [14:0] n_an,
                           input logic [11:0] n_dsn, input logic n_runn,
                           output logic [27:0] bits, output int nb, output int rck_len,
                           output int fd_cnt, output int pl_low, output int viol,
                           output int rck_rise, output logic [11:0] sr_pre, output bit done);
        logic sclk_p, rck_p;
        logic [11:0] last_sr;
        bits = '0; nb = 0; rck_len = 0; fd_cnt = 0; pl_low = 0; viol = 0;
        rck_rise = -1; sr_pre = sr; done = 1'b0;
        sclk_p = sclk; rck_p = rck; last_sr = sr;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sclk && !sclk_p) begin
                bits = {bits[26:0], sdo};
                nb++;
                if (nb == chg_at) begin An = n_an; dsn = n_dsn; runn = n_runn; end
                if (nb == rst_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    done = 1'b1;
                end
            end
            if (!done) begin
                if (!pl_n) pl_low++;
                if (sclk && (!pl_n || rck)) viol++;
                if (frame_done) fd_cnt++;
                if (rck) begin
                    rck_len++;
                    if (!rck_p) begin rck_rise = cyc; sr_pre = last_sr; end
                end
                if (!rck && rck_p) done = 1'b1;
                sclk_p = sclk; rck_p = rck; last_sr = sr;
            end
        end
    endtask

    task automatic frame();
        capture(-1, -1, An, dsn, runn, f_bits, f_nb, f_rck, f_fd, f_pl, f_viol, f_rise, f_srpre, f_done);
    endtask

    task automatic test_reset();
        reset = 1'b1; An = 15'h7FFE; dsn = 12'hAAA; runn = 1'b0;
        pins = ~{SR_BASE, DSEL_BASE};
        repeat (4) @(negedge clk);
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", sclk); end
        n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo got %b want 0", sdo); end
        n_checks++; if (rck !== 1'b0) begin n_fail++; $display("FAIL reset_rck got %b want 0", rck); end
        n_checks++; if (pl_n !== 1'b1) begin n_fail++; $display("FAIL reset_pl_n got %b want 1", pl_n); end
        n_checks++; if (sr !== 12'd0) begin n_fail++; $display("FAIL reset_sr got %o want 0", sr); end
        n_checks++; if (dsel !== 6'd0) begin n_fail++; $display("FAIL reset_dsel got %b want 0", dsel); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        logic [27:0] exp_bits;
        logic [11:0] exp_sr;
        logic [5:0]  exp_dsel;
        int exp_fd, rise1;
        exp_bits = {1'b0, 12'hAAA, 15'h7FFE};
`ifdef PANEL_DEBOUNCE_EN
        exp_sr = 12'd0; exp_dsel = 6'd0; exp_fd = 0;
`else
        exp_sr = SR_BASE; exp_dsel = DSEL_BASE; exp_fd = 1;
`endif
        frame();
        n_checks++; if (!f_done) begin n_fail++; $display("FAIL first_frame_done got timeout want rck pulse"); end
        n_checks++; if (f_bits !== exp_bits) begin n_fail++; $display("FAIL first_frame_bits got %b want %b", f_bits, exp_bits); end
        n_checks++; if (f_nb != 28) begin n_fail++; $display("FAIL first_frame_nbits got %0d want 28", f_nb); end
        n_checks++; if (f_rck != 2) begin n_fail++; $display("FAIL first_frame_rck_len got %0d want 2", f_rck); end
        n_checks++; if (f_fd != exp_fd) begin n_fail++; $display("FAIL first_frame_fd got %0d want %0d", f_fd, exp_fd); end
        n_checks++; if (sr !== exp_sr) begin n_fail++; $display("FAIL first_frame_sr got %o want %o", sr, exp_sr); end
        n_checks++; if (dsel !== exp_dsel) begin n_fail++; $display("FAIL first_frame_dsel got %b want %b", dsel, exp_dsel); end
        rise1 = f_rise;
        frame();
        n_checks++; if (f_rise - rise1 != 116) begin n_fail++; $display("FAIL frame_period got %0d want 116", f_rise - rise1); end
        n_checks++; if (f_bits !== exp_bits) begin n_fail++; $display("FAIL second_frame_bits got %b want %b", f_bits, exp_bits); end
        n_checks++; if (sr !== SR_BASE) begin n_fail++; $display("FAIL second_frame_sr got %o want %o", sr, SR_BASE); end
        n_checks++; if (f_fd != 1) begin n_fail++; $display("FAIL second_frame_fd got %0d want 1", f_fd); end
    endtask

    task automatic test_three_frames();
        for (int k = 0; k < 3; k++) begin
            frame();
            n_checks++; if (!f_done) begin n_fail++; $display("FAIL frames%0d_done got timeout want rck pulse", k); end
            n_checks++; if (f_pl != 2) begin n_fail++; $display("FAIL frames%0d_pl_low got %0d want 2", k, f_pl); end
            n_checks++; if (f_viol != 0) begin n_fail++; $display("FAIL frames%0d_sclk_overlap got %0d want 0", k, f_viol); end
        end
    endtask

    task automatic test_midframe_lamps();
        logic [27:0] old_bits, new_bits;
        old_bits = {1'b0, 12'hAAA, 15'h7FFE};
        new_bits = {1'b1, 12'h5A5, 15'h1234};
        capture(-1, 14, 15'h1234, 12'h5A5, 1'b1, f_bits, f_nb, f_rck, f_fd, f_pl, f_viol, f_rise, f_srpre, f_done);
        n_checks++; if (f_bits !== old_bits) begin n_fail++; $display("FAIL midframe_current_bits got %b want %b", f_bits, old_bits); end
        frame();
        n_checks++; if (f_bits !== new_bits) begin n_fail++; $display("FAIL midframe_next_bits got %b want %b", f_bits, new_bits); end
    endtask

    task automatic test_reset_midframe();
        logic [27:0] exp_bits;
        logic [11:0] exp_sr;
        int exp_fd;
        exp_bits = {1'b1, 12'h5A5, 15'h1234};
`ifdef PANEL_DEBOUNCE_EN
        exp_sr = 12'd0; exp_fd = 0;
`else
        exp_sr = SR_BASE; exp_fd = 1;
`endif
        capture(10, -1, An, dsn, runn, f_bits, f_nb, f_rck, f_fd, f_pl, f_viol, f_rise, f_srpre, f_done);
        n_checks++; if (f_rck != 0) begin n_fail++; $display("FAIL abort_rck got %0d want 0", f_rck); end
        n_checks++; if ({sclk, sdo, rck, pl_n} !== 4'b0001) begin n_fail++; $display("FAIL abort_pins got %b want 0001", {sclk, sdo, rck, pl_n}); end
        n_checks++; if ({sr, dsel} !== 18'd0) begin n_fail++; $display("FAIL abort_sr_dsel got %h want 0", {sr, dsel}); end
        frame();
        n_checks++; if (!f_done) begin n_fail++; $display("FAIL after_abort_done got timeout want rck pulse"); end
        n_checks++; if (f_bits !== exp_bits) begin n_fail++; $display("FAIL after_abort_bits got %b want %b", f_bits, exp_bits); end
        n_checks++; if (f_rck != 2) begin n_fail++; $display("FAIL after_abort_rck_len got %0d want 2", f_rck); end
        n_checks++; if (f_srpre !== 12'd0) begin n_fail++; $display("FAIL after_abort_sr_before got %o want 0", f_srpre); end
        n_checks++; if (sr !== exp_sr) begin n_fail++; $display("FAIL after_abort_sr got %o want %o", sr, exp_sr); end
        n_checks++; if (f_fd != exp_fd) begin n_fail++; $display("FAIL after_abort_fd got %0d want %0d", f_fd, exp_fd); end
    endtask

    task automatic test_switch_flip();
        bit          flip[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef PANEL_DEBOUNCE_EN
        int          exp_fd[5] = '{0, 0, 1, 0, 1};
        logic [11:0] exp_sr[5] = '{SR_BASE, SR_BASE, SR_BASE, SR_BASE, SR_FLIP};
`else
        int          exp_fd[5] = '{1, 1, 1, 1, 1};
        logic [11:0] exp_sr[5] = '{SR_FLIP, SR_BASE, SR_BASE, SR_FLIP, SR_FLIP};
`endif
        frame();
        n_checks++; if (sr !== SR_BASE) begin n_fail++; $display("FAIL flip_settle_sr got %o want %o", sr, SR_BASE); end
        for (int k = 0; k < 5; k++) begin
            pins = ~{(flip[k] ? SR_FLIP : SR_BASE), DSEL_BASE};
            frame();
            n_checks++; if (f_fd != exp_fd[k]) begin n_fail++; $display("FAIL flip%0d_fd got %0d want %0d", k, f_fd, exp_fd[k]); end
            n_checks++; if (sr !== exp_sr[k]) begin n_fail++; $display("FAIL flip%0d_sr got %o want %o", k, sr, exp_sr[k]); end
        end
        pins = ~{SR_BASE, DSEL_BASE};
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_three_frames();
        test_midframe_lamps();
        test_reset_midframe();
        test_switch_flip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
